gpr_access_arbiter: RTL and testbench

Shares the single-port 32x32 general-purpose register file between NUM_REQ requesters (e.g. writeback, load unit, debug). Each requester has a valid/ready handshake. Grants are round-robin, with one access per cycle. Also contains a clear sequencer that zeroes all 32 registers through the same port. Sits directly in front of the register file: it drives the file's address, write-enable and write-data and samples its combinational read data.

---
 rtl/gpr_arb_pkg.sv | 20 ++
 rtl/gpr_access_arbiter_rr_arbiter.sv | 28 ++
 rtl/gpr_access_arbiter.sv | 134 +++++++++++++
 tb/tb_gpr_access_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/gpr_arb_pkg.sv
// Shared widths, state encoding and request payload for the GPR access arbiter.
package gpr_arb_pkg;

  localparam int unsigned GPR_ADDR_W = 5;
  localparam int unsigned GPR_DATA_W = 32;
  localparam int unsigned GPR_COUNT  = 32;
  localparam int unsigned GPR_CNT_W  = $clog2(GPR_COUNT);

  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } gpr_arb_state_t;

  typedef struct packed {
    logic                  we;
    logic [GPR_ADDR_W-1:0] addr;
    logic [GPR_DATA_W-1:0] wdata;
  } gpr_req_t;

endpackage

// File: rtl/gpr_access_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request at or after ptr.
module rr_arbiter #(
  parameter int unsigned N = 3
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt
);

  localparam int unsigned PW = $clog2(N);

  // Scan ptr, ptr+1, ... modulo N and grant the first asserted request.
  always_comb begin
    logic          found;
    logic [PW-1:0] idx;
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = PW'((32'(ptr) + off) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gpr_access_arbiter.sv
// Round-robin front end for the single-port 32x32 GPR file, with a clear sequencer.
// Optional build macro ZERO_REG_EN: register 0 reads as zero and ignores writes.
module gpr_access_arbiter
  import gpr_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ADDR_W  = GPR_ADDR_W,
  parameter int unsigned DATA_W  = GPR_DATA_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear_start,
  output logic                      clear_busy,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_rdata,
  output logic                      gpr_we,
  output logic [ADDR_W-1:0]         gpr_addr,
  output logic [DATA_W-1:0]         gpr_wdata,
  input  logic [DATA_W-1:0]         gpr_rdata
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = GPR_CNT_W;

  localparam logic [0:0] ST_ARB   = 1'(ARB);
  localparam logic [0:0] ST_CLEAR = 1'(CLEAR);

  logic [0:0]         state_q,      state_d;
  logic [PTR_W-1:0]   rr_ptr_q,     rr_ptr_d;
  logic [CNT_W-1:0]   clr_cnt_q,    clr_cnt_d;
  logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]  resp_rdata_q, resp_rdata_d;

  gpr_req_t           reqs [NUM_REQ];
  gpr_req_t           sel;
  logic [NUM_REQ-1:0] gnt;
  logic [PTR_W-1:0]   gnt_idx;

  // Unpack the flat request buses into per-requester payloads.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      reqs[i].we    = req_we[i];
      reqs[i].addr  = GPR_ADDR_W'(req_addr[i*ADDR_W +: ADDR_W]);
      reqs[i].wdata = GPR_DATA_W'(req_wdata[i*DATA_W +: DATA_W]);
    end
  end

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr_arbiter (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (gnt)
  );

  // Encode the one-hot grant into an index for payload selection and pointer update.
  always_comb begin
    gnt_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) gnt_idx = PTR_W'(i);
    end
  end

  assign sel = reqs[gnt_idx];

  // Next-state, register-file port drive and response capture.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    clr_cnt_d    = clr_cnt_q;
    resp_valid_d = '0;
    resp_rdata_d = resp_rdata_q;
    req_ready    = '0;
    gpr_we       = 1'b0;
    gpr_addr     = '0;
    gpr_wdata    = '0;
    case (state_q)
      ST_ARB: begin
        if (clear_start) begin
          // A clear request pre-empts any grant in the same cycle.
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end else if (|gnt) begin
          req_ready    = gnt;
          gpr_addr     = ADDR_W'(sel.addr);
          gpr_wdata    = DATA_W'(sel.wdata);
          rr_ptr_d     = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
          resp_valid_d = gnt;
`ifdef ZERO_REG_EN
          gpr_we       = sel.we & (sel.addr != '0);
          resp_rdata_d = (sel.we || (sel.addr == '0)) ? '0 : gpr_rdata;
`else
          gpr_we       = sel.we;
          resp_rdata_d = sel.we ? '0 : gpr_rdata;
`endif
        end
      end
      ST_CLEAR: begin
        gpr_we    = 1'b1;
        gpr_addr  = ADDR_W'(clr_cnt_q);
        clr_cnt_d = clr_cnt_q + CNT_W'(1);
        if (clr_cnt_q == CNT_W'(GPR_COUNT - 1)) state_d = ST_ARB;
      end
      default: state_d = ST_ARB;
    endcase
  end

  // State and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_ARB;
      rr_ptr_q     <= '0;
      clr_cnt_q    <= '0;
      resp_valid_q <= '0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      clr_cnt_q    <= clr_cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign clear_busy = (state_q == ST_CLEAR);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_gpr_access_arbiter.sv
// Directed bench for gpr_access_arbiter with a behavioural 32x32 register file.
module tb_gpr_access_arbiter;

  localparam int unsigned NR = 3;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic             clk;
  logic             reset;
  logic             clear_start;
  logic             clear_busy;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    req_we;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]    resp_valid;
  logic [DW-1:0]    resp_rdata;
  logic             gpr_we;
  logic [AW-1:0]    gpr_addr;
  logic [DW-1:0]    gpr_wdata;
  logic [DW-1:0]    gpr_rdata;

  int n_chk  = 0;
  int n_pass = 0;

  gpr_access_arbiter #(
    .NUM_REQ (NR),
    .ADDR_W  (AW),
    .DATA_W  (DW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .gpr_we      (gpr_we),
    .gpr_addr    (gpr_addr),
    .gpr_wdata   (gpr_wdata),
    .gpr_rdata   (gpr_rdata)
  );

  // Single-port register file: synchronous write, combinational read.
  logic [DW-1:0] rf [32];
  always @(posedge clk) if (gpr_we) rf[gpr_addr] <= gpr_wdata;
  assign gpr_rdata = rf[gpr_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_we[i]              = we;
    req_addr[i*AW +: AW]   = a;
    req_wdata[i*DW +: DW]  = d;
  endtask

  // One isolated handshake from requester i, then check the response pulse.
  task automatic txn(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic [DW-1:0] exp_rd, input string tag);
    @(negedge clk);
    set_req(i, we, a, d);
    req_valid = NR'(1 << i);
    #1 check({tag, "_rdy"}, 32'(req_ready), 32'(1 << i));
    @(negedge clk);
    req_valid = '0;
    check({tag, "_rv"}, 32'(resp_valid), 32'(1 << i));
    check({tag, "_rd"}, resp_rdata, exp_rd);
  endtask

  logic [DW-1:0] exp_r0;
  logic          exp_z_we;
  logic [DW-1:0] exp_z_rd;

  initial begin
    reset       = 1'b1;
    clear_start = 1'b0;
    req_valid   = '0;
    req_we      = '0;
    req_addr    = '0;
    req_wdata   = '0;
`ifdef ZERO_REG_EN
    exp_r0   = 32'h0;
    exp_z_we = 1'b0;
    exp_z_rd = 32'h0;
`else
    exp_r0   = 32'h1;
    exp_z_we = 1'b1;
    exp_z_rd = 32'h1234;
`endif

    // Reset state.
    @(negedge clk);
    check("rst_rv",   32'(resp_valid), 32'h0);
    check("rst_rd",   resp_rdata, 32'h0);
    check("rst_busy", 32'(clear_busy), 32'h0);
    check("rst_we",   32'(gpr_we), 32'h0);
    reset = 1'b0;

    // Requester 1 writes then reads address 5.
    @(negedge clk);
    set_req(1, 1'b1, 5'd5, 32'hDEADBEEF);
    req_valid = 3'b010;
    #1;
    check("w5_rdy",  32'(req_ready), 32'h2);
    check("w5_we",   32'(gpr_we), 32'h1);
    check("w5_addr", 32'(gpr_addr), 32'h5);
    check("w5_data", gpr_wdata, 32'hDEADBEEF);
    @(negedge clk);
    req_valid = '0;
    check("w5_rv", 32'(resp_valid), 32'h2);
    check("w5_rd", resp_rdata, 32'h0);
    txn(1, 1'b0, 5'd5, 32'h0, 32'hDEADBEEF, "r5");

    // All three valid from reset: strict rotation 0,1,2,0,1,2.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) set_req(i, 1'b0, 5'd5, 32'h0);
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      #1 check("rr_rdy", 32'(req_ready), 32'(1 << (k % 3)));
      @(negedge clk);
      check("rr_rv", 32'(resp_valid), 32'(1 << (k % 3)));
      check("rr_rd", resp_rdata, 32'hDEADBEEF);
    end
    req_valid = '0;

    // Lone requester 2 gets back-to-back grants.
    set_req(2, 1'b0, 5'd5, 32'h0);
    req_valid = 3'b100;
    for (int k = 0; k < 4; k++) begin
      #1 check("b2b_rdy", 32'(req_ready), 32'h4);
      @(negedge clk);
      check("b2b_rv", 32'(resp_valid), 32'h4);
    end
    req_valid = '0;
    @(negedge clk);
    check("b2b_idle", 32'(resp_valid), 32'h0);

    // Preload every register with index+1.
    for (int k = 0; k < 32; k++) txn(0, 1'b1, AW'(k), 32'(k + 1), 32'h0, "pre");
    txn(0, 1'b0, 5'd31, 32'h0, 32'd32, "pre_r31");
    txn(0, 1'b0, 5'd0,  32'h0, exp_r0, "pre_r0");

    // Clear while requester 0 waits; a second clear_start mid-sequence is ignored.
    @(negedge clk);
    set_req(0, 1'b0, 5'd7, 32'h0);
    req_valid   = 3'b001;
    clear_start = 1'b1;
    #1 check("clr_blk", 32'(req_ready), 32'h0);
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      clear_start = (k == 20);
      #1;
      check("clr_busy", 32'(clear_busy), 32'h1);
      check("clr_we",   32'(gpr_we), 32'h1);
      check("clr_addr", 32'(gpr_addr), 32'(k));
      check("clr_rdy",  32'(req_ready), 32'h0);
      check("clr_data", gpr_wdata, 32'h0);
    end
    @(negedge clk);
    clear_start = 1'b0;
    #1;
    check("clr_done", 32'(clear_busy), 32'h0);
    check("clr_gnt0", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = '0;
    check("clr_r7", resp_rdata, 32'h0);
    for (int k = 0; k < 32; k++) txn(0, 1'b0, AW'(k), 32'h0, 32'h0, "clr_rb");

    // Reset aborts a clear at counter 10; pointer returns to requester 0.
    @(negedge clk);
    clear_start = 1'b1;
    @(negedge clk);
    clear_start = 1'b0;
    repeat (10) @(negedge clk);
    check("abt_addr", 32'(gpr_addr), 32'd10);
    check("abt_busy1", 32'(clear_busy), 32'h1);
    reset = 1'b1;
    #1;
    check("abt_busy0", 32'(clear_busy), 32'h0);
    check("abt_we",    32'(gpr_we), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) set_req(i, 1'b0, 5'd9, 32'h0);
    req_valid = 3'b111;
    #1 check("abt_gnt0", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = '0;

    // Register 0 write/read behaviour.
    @(negedge clk);
    set_req(1, 1'b1, 5'd0, 32'h1234);
    req_valid = 3'b010;
    #1 check("z_we", 32'(gpr_we), 32'(exp_z_we));
    @(negedge clk);
    req_valid = '0;
    check("z_wrv", 32'(resp_valid), 32'h2);
    txn(1, 1'b0, 5'd0, 32'h0, exp_z_rd, "z_rd");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
